// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit holding the HI/LO result registers.
// Optional madd/maddu support is enabled by defining MDU_MADD_EN.
module mdu_hilo #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Start,
  input  logic [2:0]  MDU_op,
  input  logic        HI_we,
  input  logic        LO_we,
  input  logic        HILO_sel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [63:0]       pend_q, pend_d;

  logic [63:0]       prod_s, prod_u;
  logic [31:0]       a_mag, b_mag, b_safe, q_mag, r_mag, b_usafe;
  logic [63:0]       div_s, div_u;
  logic [63:0]       op_result;
  logic [CntW-1:0]   op_cycles;
  logic              op_valid;

  // Signed results come from magnitudes so 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u  = {32'b0, A} * {32'b0, B};
    a_mag   = A[31] ? (32'd0 - A) : A;
    b_mag   = B[31] ? (32'd0 - B) : B;
    b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    b_usafe = (B == 32'd0) ? 32'd1 : B;
    q_mag   = a_mag / b_safe;
    r_mag   = a_mag % b_safe;
    if (B == 32'd0) begin
      div_s = {A, 32'hFFFF_FFFF};
      div_u = {A, 32'hFFFF_FFFF};
    end else begin
      div_s = {A[31] ? (32'd0 - r_mag) : r_mag,
               (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag};
      div_u = {A % b_usafe, A / b_usafe};
    end
  end

  always_comb begin
    op_valid  = 1'b0;
    op_result = 64'd0;
    op_cycles = CntW'(MULT_CYCLES);
    case (MDU_op)
      3'd0: begin op_valid = 1'b1; op_result = prod_s; end
      3'd1: begin op_valid = 1'b1; op_result = prod_u; end
      3'd2: begin op_valid = 1'b1; op_result = div_s; op_cycles = CntW'(DIV_CYCLES); end
      3'd3: begin op_valid = 1'b1; op_result = div_u; op_cycles = CntW'(DIV_CYCLES); end
`ifdef MDU_MADD_EN
      3'd4: begin op_valid = 1'b1; op_result = {hi_q, lo_q} + prod_s; end
      3'd5: begin op_valid = 1'b1; op_result = {hi_q, lo_q} + prod_u; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    case (state_q)
      StIdle: begin
        if (HI_we) hi_d = A;
        if (LO_we) lo_d = A;
        if (Start && op_valid) begin
          state_d = StRun;
          cnt_d   = op_cycles;
          pend_d  = op_result;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d      = StIdle;
          {hi_d, lo_d} = pend_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
    end
  end

  assign Busy   = (state_q == StRun);
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MD_out = HILO_sel ? hi_q : lo_q;

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit in the EX stage. It consumes the same rs/rt operands as the ALU and holds the HI/LO result registers.
- It signals Busy so the hazard unit can stall any later mult/div/mfhi/mflo.
- MFHI/MFLO data returns on MD_out to the EX result mux. This is the result-producing end of the operand path that the ALU B-select feeds.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (must be >= 1).
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- A  input  32  rs operand (dividend / multiplicand / mthi/mtlo data).
- B  input  32  rt operand (divisor / multiplier).
- Start  input  1  one-cycle pulse that launches the operation selected by MDU_op.
- MDU_op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=madd, 5=maddu, 6/7 reserved.
- HI_we  input  1  mthi: HI <= A.
- LO_we  input  1  mtlo: LO <= A.
- HILO_sel  input  1  1 selects HI on MD_out, 0 selects LO.
- Busy  output  1  an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- MD_out  output  32  combinational: HILO_sel ? HI : LO.

Behaviour:
- Reset: Busy=0, HI=0, LO=0, counter=0, state=IDLE. Reset mid-operation aborts the operation and discards its result.
- States: IDLE, RUN.
- IDLE to RUN: on a cycle with Start=1 and a valid op.
  - Operands are sampled that cycle. The result is computed into internal pending registers.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - Busy=1 from the next cycle.
- RUN: the counter decrements each cycle.
  - On the edge where it reaches 0, HI/LO take the pending result, Busy drops to 0 and the state returns to IDLE.
  - Busy is therefore high for exactly N cycles, starting the cycle after Start.
- Arithmetic:
  - mult: signed 32x32 to 64; HI=[63:32], LO=[31:0].
  - multu: the same, unsigned.
  - div: LO=quotient, HI=remainder, truncating toward zero; the remainder takes the sign of the dividend.
  - divu: the same, unsigned.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (div or divu with B=0): the operation still takes DIV_CYCLES; then HI=A and LO=0xFFFFFFFF.
- Start while Busy=1 is ignored. The hazard unit guarantees it stalls, and the bench checks that it is ignored.
- HI_we/LO_we while Busy=1 are ignored. The in-flight result wins.
- HI_we/LO_we in IDLE write on the next edge. If Start=1 in the same cycle, the write still applies but is overwritten when the operation completes.
- HI_we and LO_we together write both registers.
- MD_out during Busy shows the old HI/LO values. Readers must stall, and the bench does not treat this as an error.
- Reserved ops (6/7) with Start=1 are a no-op: Busy is not raised and no state changes.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - MDU_op 4 (madd): {HI,LO} <= {HI,LO} + signed(A*B).
  - MDU_op 5 (maddu): the same with an unsigned product.
  - Both take MULT_CYCLES. Accumulation is modulo 2^64, using the HI/LO value captured at Start.
- Undefined: ops 4/5 behave as reserved (no-op, Busy stays 0).

Test Plan:
- Reset, then Start mult A=0xFFFFFFFE (-2), B=3:
  - Busy high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - HILO_sel=0 gives MD_out=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF: after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=-7 (0xFFFFFFF9), B=2:
  - Busy for 10 cycles.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=0 then gives HI=7, LO=0xFFFFFFFF.
- Boundaries:
  - During a div, pulse Start (mult) and HI_we with A=0x1234 at cycle 3: both ignored, and the final HI/LO equal the div result.
  - Afterwards HI_we with A=0x1234 in IDLE: HI=0x1234 next cycle.
- Assert reset at cycle 4 of a div: Busy=0, HI=LO=0 the next cycle, and no late write occurs.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 gives HI=1, LO=0. Without the macro the same stimulus leaves Busy=0 and HI/LO unchanged.
